// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan sequencer. Build macro SCAN_SKIP_EN
// adds the masked channel lookup used to skip disabled channels.
package scan_pkg;

  localparam int SEL_W  = 3;
  localparam int MAX_CH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

`ifdef SCAN_SKIP_EN
  // Lowest enabled channel at or above cur and below num_ch.
  // MSB of the result flags that such a channel exists.
  function automatic logic [SEL_W:0] next_ch(input logic [SEL_W:0]  cur,
                                             input logic [MAX_CH-1:0] mask,
                                             input int                num_ch);
    logic [SEL_W:0] res;
    res = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (i >= int'(cur) && i < num_ch && mask[i]) begin
        res = {1'b1, SEL_W'(i)};
      end
    end
    return res;
  endfunction
`endif

endpackage

// File: rtl/dwell_timer.sv
// Counts 0..DWELL-1 while enabled and flags the last count of each dwell.
// The counter restarts on its own after expire, so it never overflows.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(DWELL + 1);

  logic [CNT_W-1:0] cnt;

  assign expire = en && (cnt == CNT_W'(DWELL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= expire ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Steps a 3-bit decoder select through channels 0..NUM_CH-1, DWELL clocks each,
// in single-shot or continuous mode. SCAN_SKIP_EN adds ch_mask channel skipping.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL  = 4,
  parameter int NUM_CH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
`ifdef SCAN_SKIP_EN
  input  logic [7:0]       ch_mask,
`endif
  output logic [SEL_W-1:0] sel,
  output logic             sel_vld,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  // Handshake: start is honoured only in IDLE with stop low; stop is honoured
  // every cycle and wins over start and over a same-cycle end of pass.

  scan_state_t      state, state_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             vld_nxt, busy_nxt, done_nxt, wrap_nxt;
  logic             mode, mode_nxt;
  logic             tmr_clr, tmr_en, expire;

  logic [SEL_W-1:0] first_sel, adv_sel;
  logic             first_ok, has_next;

`ifdef SCAN_SKIP_EN
  logic [SEL_W:0] first_lk, next_lk;

  assign first_lk  = next_ch('0, ch_mask, NUM_CH);
  assign next_lk   = next_ch({1'b0, sel} + 1'b1, ch_mask, NUM_CH);
  assign first_ok  = first_lk[SEL_W];
  assign first_sel = first_ok ? first_lk[SEL_W-1:0] : '0;
  assign has_next  = next_lk[SEL_W];
  assign adv_sel   = next_lk[SEL_W-1:0];
`else
  assign first_ok  = 1'b1;
  assign first_sel = '0;
  assign has_next  = (sel != SEL_W'(NUM_CH - 1));
  assign adv_sel   = sel + 1'b1;
`endif

  dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (expire)
  );

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    vld_nxt   = sel_vld;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    mode_nxt  = mode;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;

    unique case (state)
      IDLE: begin
        tmr_clr = 1'b1;
        if (start && !stop && first_ok) begin
          state_nxt = SCAN;
          sel_nxt   = first_sel;
          vld_nxt   = 1'b1;
          busy_nxt  = 1'b1;
          mode_nxt  = cont;
        end
      end
      SCAN: begin
        if (stop) begin
          state_nxt = IDLE;
          sel_nxt   = '0;
          vld_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          tmr_clr   = 1'b1;
        end else begin
          tmr_en = 1'b1;
          if (expire) begin
            if (has_next) begin
              sel_nxt = adv_sel;
            end else if (mode) begin
              sel_nxt  = first_sel;
              wrap_nxt = 1'b1;
            end else begin
              state_nxt = IDLE;
              sel_nxt   = '0;
              vld_nxt   = 1'b0;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      sel_vld <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
      mode    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      sel_vld <= vld_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      wrap    <= wrap_nxt;
      mode    <= mode_nxt;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: a per-cycle expectation table for the
// single-shot pass plus hand-written sequences for stop, wrap, reset and skip.
module tb_scan_sequencer;
  import scan_pkg::*;

  typedef struct packed {
    logic [2:0] sel;
    logic       vld;
    logic       busy;
    logic       done;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, stop_a = 1'b0, cont_a = 1'b0;
  logic       start_b = 1'b0, stop_b = 1'b0, cont_b = 1'b0;
  logic [7:0] mask_a = 8'hFF;
  logic [7:0] mask_b = 8'hFF;
  logic [2:0] sel_a, sel_b;
  logic       vld_a, busy_a, done_a, wrap_a;
  logic       vld_b, busy_b, done_b, wrap_b;

  int   tests = 0;
  int   fails = 0;
  exp_t tbl [1:34];
  exp_t idle_v;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL(4), .NUM_CH(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .cont(cont_a),
`ifdef SCAN_SKIP_EN
    .ch_mask(mask_a),
`endif
    .sel(sel_a), .sel_vld(vld_a), .busy(busy_a), .done(done_a), .wrap(wrap_a)
  );

  scan_sequencer #(.DWELL(1), .NUM_CH(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .cont(cont_b),
`ifdef SCAN_SKIP_EN
    .ch_mask(mask_b),
`endif
    .sel(sel_b), .sel_vld(vld_b), .busy(busy_b), .done(done_b), .wrap(wrap_b)
  );

  function automatic exp_t mk(input int s, input bit v, input bit b, input bit d, input bit w);
    exp_t e;
    e.sel = 3'(s); e.vld = v; e.busy = b; e.done = d; e.wrap = w;
    return e;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got sel=%0d vld=%b busy=%b done=%b wrap=%b, want sel=%0d vld=%b busy=%b done=%b wrap=%b",
               name, act.sel, act.vld, act.busy, act.done, act.wrap,
               exp.sel, exp.vld, exp.busy, exp.done, exp.wrap);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic exp_t out_a();
    return {sel_a, vld_a, busy_a, done_a, wrap_a};
  endfunction

  function automatic exp_t out_b();
    return {sel_b, vld_b, busy_b, done_b, wrap_b};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Pulses start before an edge and returns #1 after it, i.e. in cycle 1.
  task automatic kick_a(input logic c);
    @(negedge clk); start_a = 1'b1; cont_a = c;
    tick();
    start_a = 1'b0;
  endtask

  // Single-shot pass on u_a; a start pulse is injected in cycle inj (0 = none).
  task automatic run_single(input int inj, input string tag);
    kick_a(1'b0);
    for (int c = 1; c <= 34; c++) begin
      check($sformatf("%s c%0d", tag, c), out_a(), tbl[c]);
      start_a = (c == inj);
      tick();
    end
    start_a = 1'b0;
  endtask

  initial begin
    int wraps, dones;

    for (int c = 1; c <= 32; c++) tbl[c] = mk((c - 1) / 4, 1, 1, 0, 0);
    tbl[33] = mk(0, 0, 0, 1, 0);
    tbl[34] = mk(0, 0, 0, 0, 0);
    idle_v  = mk(0, 0, 0, 0, 0);

    #12;
    check("reset_a", out_a(), idle_v);
    check("reset_b", out_b(), idle_v);
    @(negedge clk); rst_n = 1'b1;
    tick();

    run_single(0, "single");
    run_single(21, "start_busy");

    // continuous: three passes, wrap pulses at cycles 33, 65, 97
    kick_a(1'b1);
    wraps = 0; dones = 0;
    for (int c = 1; c <= 100; c++) begin
      if (c == 32) check("cont sel7", out_a(), mk(7, 1, 1, 0, 0));
      if (c == 33) check("cont wrap", out_a(), mk(0, 1, 1, 0, 1));
      if (c == 34) check("cont post", out_a(), mk(0, 1, 1, 0, 0));
      wraps += int'(wrap_a);
      dones += int'(done_a);
      tick();
    end
    check_int("cont wraps", wraps, 3);
    check_int("cont dones", dones, 0);
    @(negedge clk); stop_a = 1'b1;
    tick(); stop_a = 1'b0;
    check("cont stop", out_a(), idle_v);

    // stop in second dwell cycle of sel=3
    kick_a(1'b0);
    for (int c = 1; c < 14; c++) tick();
    check("stop pre", out_a(), mk(3, 1, 1, 0, 0));
    stop_a = 1'b1;
    tick(); stop_a = 1'b0;
    check("stop post", out_a(), idle_v);
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      dones += int'(done_a) + int'(wrap_a);
      tick();
    end
    check_int("stop no pulse", dones, 0);

    // start and stop together in IDLE: stop wins
    @(negedge clk); start_a = 1'b1; stop_a = 1'b1;
    tick(); start_a = 1'b0; stop_a = 1'b0;
    check("start+stop", out_a(), idle_v);

    // stop on the final dwell cycle beats done
    kick_a(1'b0);
    for (int c = 1; c < 32; c++) tick();
    stop_a = 1'b1;
    tick(); stop_a = 1'b0;
    check("stop end", out_a(), idle_v);

    // DWELL=1, NUM_CH=3
    @(negedge clk); start_b = 1'b1;
    tick(); start_b = 1'b0;
    check("d1 c1", out_b(), mk(0, 1, 1, 0, 0)); tick();
    check("d1 c2", out_b(), mk(1, 1, 1, 0, 0)); tick();
    check("d1 c3", out_b(), mk(2, 1, 1, 0, 0)); tick();
    check("d1 c4", out_b(), mk(0, 0, 0, 1, 0)); tick();
    check("d1 c5", out_b(), idle_v);

`ifdef SCAN_SKIP_EN
    mask_a = 8'b1010_0101;
    kick_a(1'b0);
    for (int c = 1; c <= 17; c++) begin
      if (c <= 16)
        check($sformatf("skip c%0d", c), out_a(), mk((c <= 4) ? 0 : (c <= 8) ? 2 : (c <= 12) ? 5 : 7, 1, 1, 0, 0));
      else
        check("skip done", out_a(), mk(0, 0, 0, 1, 0));
      tick();
    end
    mask_a = 8'h00;
    kick_a(1'b0);
    check("skip mask0", out_a(), idle_v);
    mask_a = 8'hFF;
`endif

    // asynchronous reset mid-scan, checked before any further edge
    kick_a(1'b1);
    for (int c = 1; c < 10; c++) tick();
    check("pre reset", out_a(), mk(2, 1, 1, 0, 0));
    rst_n = 1'b0;
    #1;
    check("async reset", out_a(), idle_v);
    @(negedge clk); rst_n = 1'b1;
    tick();
    check("after reset", out_a(), idle_v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
